mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_LS_STREAK, default 4: max consecutive load/store grants while a fetch is pending.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  in  1  high: grants may issue; low: no new grants.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: fetch request and byte address.
REQ-006 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch accept, read-data valid, read data.
REQ-007 SHALL have ports ls_req in 1, ls_we in 1, ls_addr in 32, ls_wdata in 32, ls_be in 4: load/store request, write flag, address, data, byte enables.
REQ-008 SHALL have ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out 32: load/store accept, load-data valid, load data.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_rdata in 32: single-port memory, read data valid the cycle after an accepted read.

Function
REQ-010 SHALL issue at most one memory access per cycle; mem_req = if_gnt | ls_gnt, both combinational in the same cycle.
REQ-011 SHALL grant only when enable=1 and reset deasserted; otherwise if_gnt=ls_gnt=mem_req=0.
REQ-012 SHALL grant ls over if when both requested, unless streak counter = MAX_LS_STREAK, then grant if.
REQ-013 SHALL increment the 3-bit-min streak counter on each ls grant with if_req=1, saturate at MAX_LS_STREAK, clear on if grant or if_req=0.
REQ-014 SHALL drive mem_addr = {granted_addr[31:2], 2'b00}; address bits [1:0] ignored.
REQ-015 SHALL drive mem_we=ls_we, mem_wdata=ls_wdata, mem_be=ls_be on ls grant; on if grant mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-016 SHALL implement an owner FSM with states OWN_NONE, OWN_IF, OWN_LS, registered each cycle: OWN_IF after if grant, OWN_LS after ls read grant, OWN_NONE after ls write or no grant.
REQ-017 SHALL assert if_rvalid=1 exactly when owner=OWN_IF and ls_rvalid=1 exactly when owner=OWN_LS, each one cycle after grant.
REQ-018 SHALL route mem_rdata to both if_rdata and ls_rdata unregistered; only the matching rvalid qualifies it.
REQ-019 SHALL produce no rvalid for writes; write completion is ls_gnt.
REQ-020 SHALL support back-to-back grants every cycle, alternating owners without bubbles.
REQ-021 SHALL deliver rvalid for a read granted in the last enabled cycle even if enable drops the next cycle.
REQ-022 SHALL treat a requester as responsible for holding req/addr/data stable until its gnt; an unhandled request holds no state in the arbiter.

Reset
REQ-023 SHALL, while reset=0, force owner=OWN_NONE, streak=0, if_rvalid=ls_rvalid=0, all grants and mem_req=0.
REQ-024 SHALL drop a read in flight when reset asserts mid-operation; no rvalid after release.
REQ-025 SHALL allow a grant in the first rising edge cycle after reset release if enable=1.

Structure
REQ-026 SHALL define enum arb_owner_t {OWN_NONE, OWN_IF, OWN_LS} and default MAX_LS_STREAK in TypesPkg.
REQ-027 SHALL be a single module without sub-modules; combinational grant logic in always_comb, state in one always_ff.

Verification
REQ-028 SHALL cover: if_req only, if_addr=0x0000_0010, mem_rdata=0xDEAD_BEEF -> if_gnt same cycle, mem_addr=0x10, if_rvalid next cycle with if_rdata=0xDEAD_BEEF.
REQ-029 SHALL cover: if_req and ls_req (read) held 6 cycles, MAX_LS_STREAK=4 -> grants LS,LS,LS,LS,IF,LS.
REQ-030 SHALL cover: ls write ls_addr=0x23, ls_be=4'b0011, wdata=0x1234_5678 -> mem_addr=0x20, mem_we=1, mem_be=0011, no ls_rvalid.
REQ-031 SHALL cover: alternating if/ls reads each cycle -> if_rvalid and ls_rvalid alternate with no idle cycle.
REQ-032 SHALL cover: reset=0 asserted cycle after a read grant -> no rvalid; after release owner=OWN_NONE, streak=0.
REQ-033 SHALL cover: enable=0 with both requesting -> no grants; read granted before enable fall still returns rvalid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the instruction/data memory arbiter
package TypesPkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_t;

  localparam int DEFAULT_MAX_LS_STREAK = 4;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for one single-port memory
// Load/store wins ties until its streak hits MAX_LS_STREAK while a fetch waits.
module mem_arbiter
  import TypesPkg::*;
#(
  parameter int MAX_LS_STREAK = DEFAULT_MAX_LS_STREAK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int STREAK_W = ($clog2(MAX_LS_STREAK + 1) > 3) ? $clog2(MAX_LS_STREAK + 1) : 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  arb_owner_t          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_full;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_be      = 4'h0;
    owner_d     = OWN_NONE;
    streak_d    = streak_q;
    streak_full = (streak_q == STREAK_MAX);

    if (enable && reset) begin
      ls_gnt = ls_req && !(if_req && streak_full);
      if_gnt = if_req && !ls_gnt;
    end
    mem_req = if_gnt | ls_gnt;

    if (ls_gnt) begin
      mem_we    = ls_we;
      mem_addr  = {ls_addr[31:2], 2'b00};
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end else if (if_gnt) begin
      mem_addr  = {if_addr[31:2], 2'b00};
      mem_be    = 4'hF;
    end

    // The streak only measures how long a waiting fetch has been starved.
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end

    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !ls_we) begin
      owner_d = OWN_LS;
    end

    if_rvalid = (owner_q == OWN_IF);
    ls_rvalid = (owner_q == OWN_LS);
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic [3:0]  ls_be = 4'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending response kind (0 none, 1 fetch, 2 load) and starvation count.
  int m_streak = 0, m_pend = 0, n_streak = 0, n_pend = 0;

  always @(negedge clk) begin : model
    bit e_if, e_ls;
    if (!reset) begin
      m_streak = 0;
      m_pend   = 0;
    end
    e_ls = reset && enable && ls_req && !(if_req && m_streak >= MAXS);
    e_if = reset && enable && if_req && !e_ls;
    check("m_if_gnt", if_gnt, e_if);
    check("m_ls_gnt", ls_gnt, e_ls);
    check("m_mem_req", mem_req, e_if | e_ls);
    check("m_if_rvalid", if_rvalid, m_pend == 1);
    check("m_ls_rvalid", ls_rvalid, m_pend == 2);
    check("m_if_rdata", if_rdata, mem_rdata);
    check("m_ls_rdata", ls_rdata, mem_rdata);
    if (e_ls) begin
      check("m_ls_addr", mem_addr, ls_addr & 32'hFFFF_FFFC);
      check("m_ls_we", mem_we, ls_we);
      check("m_ls_be", mem_be, ls_be);
      check("m_ls_wdata", mem_wdata, ls_wdata);
    end else if (e_if) begin
      check("m_if_addr", mem_addr, if_addr & 32'hFFFF_FFFC);
      check("m_if_we", mem_we, 0);
      check("m_if_be", mem_be, 4'hF);
      check("m_if_wdata", mem_wdata, 0);
    end
    n_pend = e_if ? 1 : ((e_ls && !ls_we) ? 2 : 0);
    if (!if_req || e_if) n_streak = 0;
    else if (e_ls) n_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    else n_streak = m_streak;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_streak = 0;
      m_pend   = 0;
    end else begin
      m_streak = n_streak;
      m_pend   = n_pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic lsr, input logic we,
                       input logic [31:0] lsa, input logic [31:0] wd, input logic [3:0] be);
    if_req   = ifr;
    if_addr  = ifa;
    ls_req   = lsr;
    ls_we    = we;
    ls_addr  = lsa;
    ls_wdata = wd;
    ls_be    = be;
  endtask

  int exp_ls[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    // Requests during reset must not be granted.
    enable = 1'b1;
    drive(1, 32'h10, 1, 0, 32'h20, 0, 4'hF);
    repeat (2) tick();
    settle();
    check("rst_if_gnt", if_gnt, 0);
    check("rst_ls_gnt", ls_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_ls_rvalid", ls_rvalid, 0);

    // Fetch granted in the first cycle after release.
    tick();
    reset = 1'b1;
    drive(1, 32'h10, 0, 0, 0, 0, 4'h0);
    mem_rdata = 32'hDEAD_BEEF;
    settle();
    check("fetch_gnt", if_gnt, 1);
    check("fetch_addr", mem_addr, 32'h10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    settle();
    check("fetch_rvalid", if_rvalid, 1);
    check("fetch_rdata", if_rdata, 32'hDEAD_BEEF);

    // Streak limit lets the fetch through after MAXS load grants.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1, 32'h40, 1, 0, 32'h80, 0, 4'hF);
      settle();
      check("streak_ls_gnt", ls_gnt, exp_ls[i]);
      check("streak_if_gnt", if_gnt, 1 - exp_ls[i]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'h0);

    // Store with unaligned address.
    tick();
    drive(0, 0, 1, 1, 32'h23, 32'h1234_5678, 4'b0011);
    settle();
    check("wr_gnt", ls_gnt, 1);
    check("wr_addr", mem_addr, 32'h20);
    check("wr_we", mem_we, 1);
    check("wr_be", mem_be, 4'b0011);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    settle();
    check("wr_no_rvalid", ls_rvalid, 0);

    // Alternating owners, no bubbles.
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) drive(1, 32'h107, 0, 0, 0, 0, 4'h0);
      else drive(0, 0, 1, 0, 32'h20B, 0, 4'hF);
      mem_rdata = 32'hA0 + i;
      settle();
      check("alt_mem_req", mem_req, 1);
      if (i > 0) begin
        check("alt_if_rvalid", if_rvalid, (i % 2 == 1));
        check("alt_ls_rvalid", ls_rvalid, (i % 2 == 0));
      end
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    settle();
    check("alt_last_ls_rvalid", ls_rvalid, 1);
    check("alt_last_ls_rdata", ls_rdata, 32'hA5);

    // Reset mid-read drops the response and clears the streak.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1, 32'h40, 1, 0, 32'h80, 0, 4'hF);
    end
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    settle();
    check("rst_mid_ls_rvalid", ls_rvalid, 0);
    check("rst_mid_if_rvalid", if_rvalid, 0);
    tick();
    reset = 1'b1;
    settle();
    check("rel_ls_rvalid", ls_rvalid, 0);
    check("rel_if_rvalid", if_rvalid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1, 32'h40, 1, 0, 32'h80, 0, 4'hF);
      settle();
      check("rel_streak_ls_gnt", ls_gnt, (i < 4));
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'h0);

    // Enable drop: no new grants, in-flight read still completes.
    tick();
    drive(1, 32'h300, 0, 0, 0, 0, 4'h0);
    settle();
    check("en_if_gnt", if_gnt, 1);
    tick();
    enable = 1'b0;
    drive(1, 32'h300, 1, 0, 32'h400, 0, 4'hF);
    settle();
    check("dis_if_gnt", if_gnt, 0);
    check("dis_ls_gnt", ls_gnt, 0);
    check("dis_mem_req", mem_req, 0);
    check("dis_if_rvalid", if_rvalid, 1);
    tick();
    settle();
    check("dis_quiet_rvalid", if_rvalid, 0);
    tick();
    enable = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
